// File: rtl/mips_lite_pkg.sv
// Shared MIPS-lite encodings: opcodes, functs, ALU ctl codes
// and the EX control bundle used by the ID/EX stage.
package mips_lite_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    BSEL_RT,
    BSEL_IMM,
    BSEL_SHAMT
  } bsel_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ex_ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding select for one EX operand: EX/MEM beats MEM/WB,
// register 0 is never forwarded. Ports: idx, regfile data, two taps, out.
module fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] idx_i,
  input  logic [DW-1:0] reg_data_i,
  input  logic          exmem_we_i,
  input  logic [RW-1:0] exmem_dst_i,
  input  logic [DW-1:0] exmem_data_i,
  input  logic          memwb_we_i,
  input  logic [RW-1:0] memwb_dst_i,
  input  logic [DW-1:0] memwb_data_i,
  output logic [DW-1:0] data_o
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_we_i
                   && (exmem_dst_i != '0)
                   && (exmem_dst_i == idx_i);
  assign memwb_hit = memwb_we_i
                   && (memwb_dst_i != '0)
                   && (memwb_dst_i == idx_i);

  always_comb begin
    data_o = reg_data_i;
    if (exmem_hit)      data_o = exmem_data_i;
    else if (memwb_hit) data_o = memwb_data_i;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with ALU decode, operand forwarding and load-use stall.
// In: ID fields/control, flush, EX/MEM + MEM/WB taps. Out: ex_* to ALU/MEM.
module id_ex_operand_stage
  import mips_lite_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [4:0]    id_shamt,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_dst,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          id_branch,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_dst,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_dst,
  input  logic [DW-1:0] memwb_data,
  output logic          load_use_stall,
  output logic          ex_valid,
  output logic [2:0]    ex_alu_ctl,
  output logic [DW-1:0] ex_alu_a,
  output logic [DW-1:0] ex_alu_b,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dst,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_branch,
  output logic          ex_illegal
);

  logic          valid_q, valid_d;
  ex_ctrl_t      ctrl_q, ctrl_d;
  logic [2:0]    ctl_q, ctl_d;
  logic          ill_q, ill_d;
  logic          a_rt_q, a_rt_d;
  bsel_e         bsel_q, bsel_d;
  logic [RW-1:0] rs_q, rt_q, dst_q;
  logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
  logic [4:0]    shamt_q;

  logic [2:0] dec_ctl;
  logic       dec_ill;
  logic       dec_a_rt;
  bsel_e      dec_bsel;
  logic       is_r;
  logic       bubble;
  logic [DW-1:0] fwd_rs, fwd_rt;

  assign is_r = (id_opcode == OP_RTYPE);

  always_comb begin
    dec_ctl  = ALU_ADD;
    dec_ill  = 1'b0;
    dec_a_rt = 1'b0;
    dec_bsel = BSEL_RT;
    unique case (1'b1)
      is_r && id_funct == FN_ADD: dec_ctl = ALU_ADD;
      is_r && id_funct == FN_SUB: dec_ctl = ALU_SUB;
      is_r && id_funct == FN_AND: dec_ctl = ALU_AND;
      is_r && id_funct == FN_OR:  dec_ctl = ALU_OR;
      is_r && id_funct == FN_SLT: dec_ctl = ALU_SLT;
      is_r && id_funct == FN_SRL: begin
        dec_ctl  = ALU_SRL;
        dec_a_rt = 1'b1;
        dec_bsel = BSEL_SHAMT;
      end
      id_opcode == OP_LW,
      id_opcode == OP_SW,
      id_opcode == OP_ADDI: begin
        dec_ctl  = ALU_ADD;
        dec_bsel = BSEL_IMM;
      end
      id_opcode == OP_BEQ: dec_ctl = ALU_SUB;
      default: dec_ill = 1'b1;
    endcase
  end

  // Only a loaded value still in EX can't be forwarded yet.
  assign load_use_stall = valid_q
                        & ctrl_q.mem_read
                        & (dst_q != '0)
                        & id_valid
                        & ((dst_q == id_rs) | (dst_q == id_rt));

  // Empty ID slots are also captured as bubbles so no
  // write-enable rides along with an invalid instruction.
  assign bubble = flush | load_use_stall | ~id_valid;

  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = '0;
    ctl_d   = ALU_AND;
    ill_d   = 1'b0;
    a_rt_d  = 1'b0;
    bsel_d  = BSEL_RT;
    if (!bubble) begin
      valid_d           = 1'b1;
      ctrl_d.reg_write  = id_reg_write & ~dec_ill;
      ctrl_d.mem_read   = id_mem_read;
      ctrl_d.mem_write  = id_mem_write & ~dec_ill;
      ctrl_d.mem_to_reg = id_mem_to_reg;
      ctrl_d.branch     = id_branch;
      ctl_d             = dec_ctl;
      ill_d             = dec_ill;
      a_rt_d            = dec_a_rt;
      bsel_d            = dec_bsel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      ctl_q     <= ALU_AND;
      ill_q     <= 1'b0;
      a_rt_q    <= 1'b0;
      bsel_q    <= BSEL_RT;
      rs_q      <= '0;
      rt_q      <= '0;
      dst_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      shamt_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      ctl_q     <= ctl_d;
      ill_q     <= ill_d;
      a_rt_q    <= a_rt_d;
      bsel_q    <= bsel_d;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      dst_q     <= id_dst;
      rs_data_q <= id_rs_data;
      rt_data_q <= id_rt_data;
      imm_q     <= id_imm;
      shamt_q   <= id_shamt;
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .idx_i        (rs_q),
    .reg_data_i   (rs_data_q),
    .exmem_we_i   (exmem_reg_write),
    .exmem_dst_i  (exmem_dst),
    .exmem_data_i (exmem_result),
    .memwb_we_i   (memwb_reg_write),
    .memwb_dst_i  (memwb_dst),
    .memwb_data_i (memwb_data),
    .data_o       (fwd_rs)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .idx_i        (rt_q),
    .reg_data_i   (rt_data_q),
    .exmem_we_i   (exmem_reg_write),
    .exmem_dst_i  (exmem_dst),
    .exmem_data_i (exmem_result),
    .memwb_we_i   (memwb_reg_write),
    .memwb_dst_i  (memwb_dst),
    .memwb_data_i (memwb_data),
    .data_o       (fwd_rt)
  );

  assign ex_alu_a = a_rt_q ? fwd_rt : fwd_rs;

  always_comb begin
    case (bsel_q)
      BSEL_IMM:   ex_alu_b = imm_q;
      BSEL_SHAMT: ex_alu_b = {{(DW-5){1'b0}}, shamt_q};
      default:    ex_alu_b = fwd_rt;
    endcase
  end

  assign ex_store_data = fwd_rt;
  assign ex_valid      = valid_q;
  assign ex_alu_ctl    = ctl_q;
  assign ex_dst        = dst_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_branch     = ctrl_q.branch;
  assign ex_illegal    = ill_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus
// randomized instructions against a table-driven reference model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_shamt, id_rs, id_rt, id_dst;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        id_mem_to_reg, id_branch, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_dst, memwb_dst;
  logic [31:0] exmem_result, memwb_data;
  logic        load_use_stall, ex_valid;
  logic [2:0]  ex_alu_ctl;
  logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
  logic [4:0]  ex_dst;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_branch, ex_illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_funct(id_funct), .id_shamt(id_shamt),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_dst(exmem_dst),
    .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
    .memwb_dst(memwb_dst), .memwb_data(memwb_data),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid),
    .ex_alu_ctl(ex_alu_ctl), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_store_data(ex_store_data), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  // Legal encodings: opcode, any-funct flag, funct, ctl, a-from-rt, b kind
  // (b kind: 0 = rt operand, 1 = immediate, 2 = shift amount).
  localparam int NT = 10;
  localparam logic [5:0] T_OP  [NT] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                        6'h00, 6'h23, 6'h2B, 6'h08, 6'h04};
  localparam logic       T_ANY [NT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [5:0] T_FN  [NT] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A,
                                        6'h02, 6'h00, 6'h00, 6'h00, 6'h00};
  localparam logic [2:0] T_CTL [NT] = '{3'b010, 3'b110, 3'b000, 3'b001,
                                        3'b111, 3'b011, 3'b010, 3'b010,
                                        3'b010, 3'b110};
  localparam logic       T_SRL [NT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam int         T_BK  [NT] = '{0, 0, 0, 0, 0, 2, 1, 1, 1, 0};

  function automatic void lookup(input logic [5:0] op, input logic [5:0] fn,
                                 output logic [2:0] ctl, output logic ill,
                                 output logic srl, output int bk);
    ctl = 3'b010; ill = 1'b1; srl = 1'b0; bk = 0;
    for (int k = 0; k < NT; k++)
      if (T_OP[k] == op && (T_ANY[k] || T_FN[k] == fn)) begin
        ctl = T_CTL[k]; ill = 1'b0; srl = T_SRL[k]; bk = T_BK[k];
      end
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx,
                                      input logic [31:0] rv);
    if (idx == 0) return rv;
    if (exmem_reg_write && exmem_dst == idx) return exmem_result;
    if (memwb_reg_write && memwb_dst == idx) return memwb_data;
    return rv;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_taps(input logic w1, input logic [4:0] d1,
                          input logic [31:0] r1, input logic w2,
                          input logic [4:0] d2, input logic [31:0] r2);
    exmem_reg_write = w1; exmem_dst = d1; exmem_result = r1;
    memwb_reg_write = w2; memwb_dst = d2; memwb_data = r2;
  endtask

  // c = {reg_write, mem_read, mem_write, mem_to_reg, branch}
  task automatic set_id(input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dst, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [31:0] imm,
                        input logic [4:0] sh, input logic [4:0] c);
    id_valid = 1'b1; id_opcode = op; id_funct = fn;
    id_rs = rs; id_rt = rt; id_dst = dst;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = c;
  endtask

  task automatic clear_inputs();
    set_id(6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    id_valid = 1'b0;
    flush = 1'b0;
    set_taps(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    logic [111:0] obs;
    logic [31:0] a, b;
    rst = 1'b0;
    clear_inputs();
    #2;
    obs = {ex_valid, ex_alu_ctl, ex_alu_a, ex_alu_b, ex_store_data, ex_dst,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_branch, ex_illegal, load_use_stall};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_initial got=%h want=0", obs);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    set_id(6'h23, 6'h00, 5'd1, 5'd7, 5'd7, 32'h55, 32'h66, 32'h8,
           5'd0, 5'b11010);
    tick();
    #2 rst = 1'b0;
    #1;
    obs = {ex_valid, ex_alu_ctl, ex_alu_a, ex_alu_b, ex_store_data, ex_dst,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_branch, ex_illegal, load_use_stall};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_midrun got=%h want=0", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    a = $urandom; b = $urandom;
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, a, b, 32'h0, 5'd0, 5'b10000);
    tick();
    checks++;
    if ({ex_valid, ex_reg_write, ex_alu_ctl, ex_alu_a, ex_alu_b}
        !== {1'b1, 1'b1, 3'b010, a, b}) begin
      failures++;
      $display("FAIL reset_then_add got v=%b rw=%b ctl=%b a=%h b=%h want 1 1 010 %h %h",
               ex_valid, ex_reg_write, ex_alu_ctl, ex_alu_a, ex_alu_b, a, b);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h111, 32'h222, 32'h0,
           5'd0, 5'b10000);
    tick();
    set_taps(1'b1, 5'd1, 32'h10, 1'b1, 5'd1, 32'h20);
    #1;
    checks++;
    if (ex_alu_a !== 32'h10 || ex_alu_b !== 32'h222) begin
      failures++;
      $display("FAIL fwd_exmem_wins got a=%h b=%h want 10 222",
               ex_alu_a, ex_alu_b);
    end
    set_taps(1'b1, 5'd3, 32'h10, 1'b1, 5'd1, 32'h20);
    #1;
    checks++;
    if (ex_alu_a !== 32'h20) begin
      failures++;
      $display("FAIL fwd_memwb got a=%h want 20", ex_alu_a);
    end
    set_taps(1'b0, 5'd1, 32'h10, 1'b0, 5'd1, 32'h20);
    #1;
    checks++;
    if (ex_alu_a !== 32'h111) begin
      failures++;
      $display("FAIL fwd_none got a=%h want 111", ex_alu_a);
    end
    set_taps(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h77);
    #1;
    checks++;
    if (ex_alu_b !== 32'h77 || ex_store_data !== 32'h77) begin
      failures++;
      $display("FAIL fwd_rt got b=%h sd=%h want 77 77",
               ex_alu_b, ex_store_data);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_id(6'h23, 6'h00, 5'd1, 5'd4, 5'd4, 32'h0, 32'h0, 32'h4,
           5'd0, 5'b11010);
    tick();
    set_id(6'h00, 6'h20, 5'd4, 5'd2, 5'd5, 32'h999, 32'h3, 32'h0,
           5'd0, 5'b10000);
    #1;
    checks++;
    if (load_use_stall !== 1'b1) begin
      failures++;
      $display("FAIL loaduse_stall got=%b want=1", load_use_stall);
    end
    tick();
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, load_use_stall} !== 4'b0000) begin
      failures++;
      $display("FAIL loaduse_bubble got v/rw/mr/stall=%b%b%b%b want 0000",
               ex_valid, ex_reg_write, ex_mem_read, load_use_stall);
    end
    tick();
    set_taps(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hAB);
    #1;
    checks++;
    if ({ex_valid, ex_reg_write, ex_alu_a, ex_alu_b, ex_dst}
        !== {1'b1, 1'b1, 32'hAB, 32'h3, 5'd5}) begin
      failures++;
      $display("FAIL loaduse_fwd got v=%b rw=%b a=%h b=%h dst=%0d want 1 1 ab 3 5",
               ex_valid, ex_reg_write, ex_alu_a, ex_alu_b, ex_dst);
    end
  endtask

  task automatic test_zero_guard();
    clear_inputs();
    set_id(6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h4,
           5'd0, 5'b11010);
    tick();
    set_id(6'h00, 6'h20, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0,
           5'd0, 5'b10000);
    #1;
    checks++;
    if (load_use_stall !== 1'b0) begin
      failures++;
      $display("FAIL zero_nostall got=%b want=0", load_use_stall);
    end
    tick();
    set_taps(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    #1;
    checks++;
    if (ex_alu_a !== 32'h0 || ex_alu_b !== 32'h0) begin
      failures++;
      $display("FAIL zero_fwd got a=%h b=%h want 0 0", ex_alu_a, ex_alu_b);
    end
  endtask

  task automatic test_srl();
    clear_inputs();
    set_id(6'h00, 6'h02, 5'd0, 5'd5, 5'd2, 32'h1234, 32'hF0, 32'hFFFF,
           5'd4, 5'b10000);
    tick();
    checks++;
    if ({ex_alu_ctl, ex_alu_a, ex_alu_b} !== {3'b011, 32'hF0, 32'd4}) begin
      failures++;
      $display("FAIL srl got ctl=%b a=%h b=%h want 011 f0 4",
               ex_alu_ctl, ex_alu_a, ex_alu_b);
    end
  endtask

  task automatic test_flush_stall();
    clear_inputs();
    set_id(6'h23, 6'h00, 5'd1, 5'd4, 5'd4, 32'h0, 32'h0, 32'h4,
           5'd0, 5'b11010);
    tick();
    set_id(6'h00, 6'h22, 5'd4, 5'd2, 5'd6, 32'h0, 32'h0, 32'h0,
           5'd0, 5'b10000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({ex_valid, ex_reg_write, load_use_stall} !== 3'b000) begin
      failures++;
      $display("FAIL flush_stall_bubble got v/rw/stall=%b%b%b want 000",
               ex_valid, ex_reg_write, load_use_stall);
    end
    tick();
    checks++;
    if ({ex_valid, ex_reg_write, ex_alu_ctl, ex_dst}
        !== {1'b1, 1'b1, 3'b110, 5'd6}) begin
      failures++;
      $display("FAIL flush_stall_single got v=%b rw=%b ctl=%b dst=%0d want 1 1 110 6",
               ex_valid, ex_reg_write, ex_alu_ctl, ex_dst);
    end
  endtask

  task automatic test_illegal();
    clear_inputs();
    set_id(6'h3F, 6'h20, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3,
           5'd0, 5'b10100);
    tick();
    checks++;
    if ({ex_valid, ex_illegal, ex_reg_write, ex_mem_write, ex_alu_ctl}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 3'b010}) begin
      failures++;
      $display("FAIL illegal got v=%b ill=%b rw=%b mw=%b ctl=%b want 1 1 0 0 010",
               ex_valid, ex_illegal, ex_reg_write, ex_mem_write, ex_alu_ctl);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [9] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B,
                            6'h08, 6'h04, 6'h3F, 6'h0D};
    logic [5:0] fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A,
                            6'h02, 6'h27, 6'h00};
    logic       m_valid, m_mr;
    logic [4:0] m_dst;
    clear_inputs();
    id_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_valid = 1'b0; m_mr = 1'b0; m_dst = 5'd0;
    for (int i = 0; i < 300; i++) begin
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, dst, sh, c;
      logic [31:0] rsd, rtd, imm, ea, eb, es;
      logic [2:0]  ectl;
      logic        eill, esrl, estall, ev;
      int          bk;
      op = ops[$urandom_range(0, 8)];
      fn = fns[$urandom_range(0, 7)];
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      dst = 5'($urandom_range(0, 7));
      rsd = $urandom; rtd = $urandom; imm = $urandom;
      sh = 5'($urandom); c = 5'($urandom);
      set_id(op, fn, rs, rt, dst, rsd, rtd, imm, sh, c);
      flush = ($urandom_range(0, 9) == 0);
      set_taps(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      #1;
      estall = m_valid && m_mr && m_dst != 0 && (m_dst == rs || m_dst == rt);
      checks++;
      if (load_use_stall !== estall) begin
        failures++;
        $display("FAIL rnd_stall[%0d] got=%b want=%b", i, load_use_stall, estall);
      end
      ev = !(flush || estall);
      lookup(op, fn, ectl, eill, esrl, bk);
      tick();
      checks++;
      if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_branch}
          !== {ev, ev & c[4] & ~eill, ev & c[3], ev & c[2] & ~eill,
               ev & c[1], ev & c[0]}) begin
        failures++;
        $display("FAIL rnd_ctrl[%0d] got v/rw/mr/mw/m2r/br=%b%b%b%b%b%b want v=%b c=%b ill=%b",
                 i, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                 ex_mem_to_reg, ex_branch, ev, c, eill);
      end
      if (ev) begin
        ea = esrl ? fwd(rt, rtd) : fwd(rs, rsd);
        eb = (bk == 1) ? imm : (bk == 2) ? {27'd0, sh} : fwd(rt, rtd);
        es = fwd(rt, rtd);
        checks++;
        if ({ex_alu_ctl, ex_illegal, ex_dst, ex_alu_a, ex_alu_b, ex_store_data}
            !== {ectl, eill, dst, ea, eb, es}) begin
          failures++;
          $display("FAIL rnd_data[%0d] got ctl=%b ill=%b dst=%0d a=%h b=%h sd=%h want %b %b %0d %h %h %h",
                   i, ex_alu_ctl, ex_illegal, ex_dst, ex_alu_a, ex_alu_b,
                   ex_store_data, ectl, eill, dst, ea, eb, es);
        end
      end
      m_valid = ev; m_mr = ev & c[3]; m_dst = dst;
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_zero_guard();
    test_srl();
    test_flush_stall();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
